// File: rtl/fpu_dp_subtractor_seq.sv
// Multi-cycle double-precision add/subtract unit.
// One operation in flight; alignment and normalisation move one bit per cycle.
// Encodings: exp==0 && man==0 is zero, everything else is a normal number with
// hidden bit 1. Rounding is truncation.
module fpu_dp_subtractor_seq #(
    parameter int EXP_W     = 11,
    parameter int MAN_W     = 52,
    parameter int MAX_SHIFT = 54
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   op,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);

    localparam int TOP   = EXP_W + MAN_W;   // sign bit index
    localparam int SIG_W = MAN_W + 1;       // significand with hidden bit
    localparam int SUM_W = MAN_W + 2;       // significand plus carry bit

    localparam logic [EXP_W-1:0] EXP_ONE   = EXP_W'(1);
    localparam logic [EXP_W-1:0] EXP_MAX   = '1;
    localparam logic [EXP_W-1:0] SHIFT_LIM = EXP_W'(MAX_SHIFT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               s1_q, s1_d;
    logic               s2_q, s2_d;
    logic [EXP_W-1:0]   e_q, e_d;
    logic [EXP_W-1:0]   diff_q, diff_d;
    logic [SIG_W-1:0]   m1_q, m1_d;
    logic [SIG_W-1:0]   m2_q, m2_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [TOP:0]       result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;

    // Operand decode for the accept cycle
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   ma, mb;
    logic               a_zero, b_zero, sb_eff, a_ge_b;
    logic [EXP_W-1:0]   e_inc;

    assign ea     = a[TOP-1:MAN_W];
    assign eb     = b[TOP-1:MAN_W];
    assign ma     = a[MAN_W-1:0];
    assign mb     = b[MAN_W-1:0];
    assign a_zero = (ea == '0) && (ma == '0);
    assign b_zero = (eb == '0) && (mb == '0);
    assign sb_eff = b[TOP] ^ op;
    assign a_ge_b = (ea > eb) || ((ea == eb) && (ma >= mb));
    assign e_inc  = e_q + EXP_ONE;

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            e_q      <= '0;
            diff_q   <= '0;
            m1_q     <= '0;
            m2_q     <= '0;
            sum_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            e_q      <= e_d;
            diff_q   <= diff_d;
            m1_q     <= m1_d;
            m2_q     <= m2_d;
            sum_q    <= sum_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Next-state and datapath update, one action per state per cycle
    always_comb begin
        state_d  = state_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        e_d      = e_q;
        diff_d   = diff_q;
        m1_d     = m1_q;
        m2_d     = m2_q;
        sum_d    = sum_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    ovf_d = 1'b0;
                    unf_d = 1'b0;
                    if (a_zero && b_zero) begin
                        result_d = '0;
                        state_d  = S_DONE;
                    end else if (a_zero) begin
                        result_d = {sb_eff, b[TOP-1:0]};
                        state_d  = S_DONE;
                    end else if (b_zero) begin
                        result_d = a;
                        state_d  = S_DONE;
                    end else begin
                        // op1 always holds the larger magnitude so the
                        // subtraction below can never go negative
                        if (a_ge_b) begin
                            s1_d   = a[TOP];
                            s2_d   = sb_eff;
                            e_d    = ea;
                            m1_d   = {1'b1, ma};
                            m2_d   = {1'b1, mb};
                            diff_d = ea - eb;
                        end else begin
                            s1_d   = sb_eff;
                            s2_d   = a[TOP];
                            e_d    = eb;
                            m1_d   = {1'b1, mb};
                            m2_d   = {1'b1, ma};
                            diff_d = eb - ea;
                        end
                        state_d = S_ALIGN;
                    end
                end
            end
            S_ALIGN: begin
                if (diff_q >= SHIFT_LIM) begin
                    m2_d    = '0;
                    state_d = S_ADD;
                end else if (diff_q == '0) begin
                    state_d = S_ADD;
                end else begin
                    m2_d   = m2_q >> 1;
                    diff_d = diff_q - EXP_ONE;
                end
            end
            S_ADD: begin
                if (s1_q == s2_q) begin
                    sum_d = {1'b0, m1_q} + {1'b0, m2_q};
                end else begin
                    sum_d = {1'b0, m1_q} - {1'b0, m2_q};
                end
                state_d = S_NORM;
            end
            S_NORM: begin
                if (sum_q == '0) begin
                    result_d = '0;
                    state_d  = S_DONE;
                end else if (sum_q[SUM_W-1]) begin
                    sum_d = sum_q >> 1;
                    e_d   = e_inc;
                    if (e_inc == EXP_MAX) begin
                        ovf_d    = 1'b1;
                        result_d = {s1_q, EXP_MAX, {MAN_W{1'b0}}};
                        state_d  = S_DONE;
                    end
                end else if (!sum_q[SUM_W-2] && (e_q == EXP_ONE)) begin
                    unf_d    = 1'b1;
                    result_d = {s1_q, {TOP{1'b0}}};
                    state_d  = S_DONE;
                end else if (!sum_q[SUM_W-2]) begin
                    sum_d = sum_q << 1;
                    e_d   = e_q - EXP_ONE;
                end else begin
                    result_d = {s1_q, e_q, sum_q[MAN_W-1:0]};
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
